// File: rtl/mult8x8_seq_ctrl.sv
// Sequenced 8x8 unsigned multiplier: one shared 4x4 nibble multiplier and a
// 16-bit accumulator, stepped through the four partial products by an FSM.
//
// state | meaning
// IDLE  | waiting for start; operands latched and acc cleared on accept
// LSB   | acc += a[3:0]*b[3:0]
// MID1  | acc += (a[7:4]*b[3:0]) << 4
// MID2  | acc += (a[3:0]*b[7:4]) << 4
// MSB   | acc += (a[7:4]*b[7:4]) << 8; final sum also loaded into product
// DONE  | done_flag pulse; start ignored; always returns to IDLE
module mult8x8_seq_ctrl (
    input  logic        clk,
    input  logic        reset_a,
    input  logic        start,
    input  logic [7:0]  dataa,
    input  logic [7:0]  datab,
    output logic [15:0] product8x8_out,
    output logic        done_flag,
    output logic        busy,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LSB  = 3'd1,
        MID1 = 3'd2,
        MID2 = 3'd3,
        MSB  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  a_r;
    logic [7:0]  b_r;
    logic [15:0] acc;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [1:0]  shift_sel;
    logic [7:0]  pp;
    logic [15:0] pp_sh;
    logic [15:0] sum;
    logic        load_ops;
    logic        acc_en;
    logic        load_prod;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        sel_a     = a_r[3:0];
        sel_b     = b_r[3:0];
        shift_sel = 2'd0;
        load_ops  = 1'b0;
        acc_en    = 1'b0;
        load_prod = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_ops  = 1'b1;
                    state_nxt = LSB;
                end else begin
                    state_nxt = IDLE;
                end
            end
            LSB: begin
                acc_en    = 1'b1;
                state_nxt = MID1;
            end
            MID1: begin
                sel_a     = a_r[7:4];
                shift_sel = 2'd1;
                acc_en    = 1'b1;
                state_nxt = MID2;
            end
            MID2: begin
                sel_b     = b_r[7:4];
                shift_sel = 2'd1;
                acc_en    = 1'b1;
                state_nxt = MSB;
            end
            MSB: begin
                sel_a     = a_r[7:4];
                sel_b     = b_r[7:4];
                shift_sel = 2'd2;
                acc_en    = 1'b1;
                load_prod = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pp = {4'b0000, sel_a} * {4'b0000, sel_b};

    always_comb begin
        pp_sh = {8'h00, pp};
        case (shift_sel)
            2'd1:    pp_sh = {4'h0, pp, 4'h0};
            2'd2:    pp_sh = {pp, 8'h00};
            default: pp_sh = {8'h00, pp};
        endcase
    end

    // Carry-out is dropped: 255*255 fits in 16 bits.
    assign sum = acc + pp_sh;

    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            a_r            <= 8'h00;
            b_r            <= 8'h00;
            acc            <= 16'h0000;
            product8x8_out <= 16'h0000;
        end else begin
            if (load_ops) begin
                a_r <= dataa;
                b_r <= datab;
                acc <= 16'h0000;
            end else if (acc_en) begin
                acc <= sum;
            end
            if (load_prod) begin
                product8x8_out <= sum;
            end
        end
    end

    assign done_flag = (state == DONE);
    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Bench for mult8x8_seq_ctrl: a cycle-count model of the operation timeline is
// compared against the DUT every cycle, plus directed literal product checks.
module tb_mult8x8_seq_ctrl;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] product8x8_out;
    logic        done_flag;
    logic        busy;
    logic [2:0]  state_out;

    int n_vec;
    int n_err;

    // Model: phase = cycles elapsed since the accepted start (0 when idle).
    logic [2:0]  m_phase;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [15:0] m_prod;

    mult8x8_seq_ctrl dut (
        .clk            (clk),
        .reset_a        (reset_a),
        .start          (start),
        .dataa          (dataa),
        .datab          (datab),
        .product8x8_out (product8x8_out),
        .done_flag      (done_flag),
        .busy           (busy),
        .state_out      (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            m_phase <= 3'd0;
            m_a     <= 8'h00;
            m_b     <= 8'h00;
            m_prod  <= 16'h0000;
        end else if (m_phase == 3'd0) begin
            if (start) begin
                m_phase <= 3'd1;
                m_a     <= dataa;
                m_b     <= datab;
            end
        end else if (m_phase == 3'd5) begin
            m_phase <= 3'd0;
        end else begin
            m_phase <= m_phase + 3'd1;
            if (m_phase == 3'd4) m_prod <= 16'(m_a) * 16'(m_b);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Waits for done_flag (bounded); returns the number of negedges taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done_flag === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit scramble);
        int cyc;
        @(negedge clk);
        dataa = a;
        datab = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            dataa = 8'($urandom);
            datab = 8'($urandom);
        end
        wait_done(cyc);
        // already one negedge consumed after start; done arrives on the 5th
        chk({name, "_latency"}, 16'(cyc + 1), 16'd5);
        chk({name, "_product"}, product8x8_out, exp);
    endtask

    initial begin
        int cyc;
        int dones;
        int busy_low;
        logic [7:0] ra;
        logic [7:0] rb;
        n_vec   = 0;
        n_err   = 0;
        reset_a = 1'b1;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;
        #1;
        chk("reset_product", product8x8_out, 16'h0000);
        chk("reset_state", 16'(state_out), 16'd0);
        chk("reset_busy_done", {14'd0, busy, done_flag}, 16'd0);
        #20;
        @(negedge clk);
        reset_a = 1'b0;

        fork
            forever begin
                @(negedge clk);
                n_vec++;
                if (state_out !== m_phase || busy !== (m_phase != 3'd0) ||
                    done_flag !== (m_phase == 3'd5) || product8x8_out !== m_prod) begin
                    n_err++;
                    $display("FAIL cycle_check t=%0t: state=%0d busy=%b done=%b prod=0x%04h expected state=%0d busy=%b done=%b prod=0x%04h",
                             $time, state_out, busy, done_flag, product8x8_out,
                             m_phase, (m_phase != 3'd0), (m_phase == 3'd5), m_prod);
                end
            end
        join_none

        // basic products
        run_op("t1_12x34", 8'h12, 8'h34, 16'h03A8, 1'b0);
        run_op("t2_ffxff", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        run_op("t2_00xa5", 8'h00, 8'hA5, 16'h0000, 1'b0);
        run_op("t2_80x02", 8'h80, 8'h02, 16'h0100, 1'b0);

        // second start during MID1 is ignored
        @(negedge clk);
        dataa = 8'h0F; datab = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dataa = 8'h33; datab = 8'h33;
        @(negedge clk);
        chk("t3_in_mid1", 16'(state_out), 16'd2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("t3_done_seen", 16'(cyc != 0), 16'd1);
        chk("t3_product", product8x8_out, 16'h00F0);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_flag) dones++;
        end
        chk("t3_no_second_done", 16'(dones), 16'd0);
        chk("t3_idle", 16'(state_out), 16'd0);

        // start held high: one product every 6 cycles
        @(negedge clk);
        dataa = 8'h03; datab = 8'h05; start = 1'b1;
        dones = 0;
        busy_low = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (i == 24) start = 1'b0;
            if (done_flag) begin
                dones++;
                chk("t4_product", product8x8_out, 16'h000F);
            end
            if (!busy) busy_low++;
        end
        chk("t4_done_count", 16'(dones), 16'd4);
        chk("t4_busy_low_cycles", 16'(busy_low), 16'd4);

        // async reset in MID2
        @(negedge clk);
        dataa = 8'hC8; datab = 8'h64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_mid2", 16'(state_out), 16'd3);
        @(posedge clk);
        #2;
        reset_a = 1'b1;
        #1;
        chk("t5_rst_state", 16'(state_out), 16'd0);
        chk("t5_rst_product", product8x8_out, 16'h0000);
        chk("t5_rst_busy_done", {14'd0, busy, done_flag}, 16'd0);
        @(negedge clk);
        reset_a = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_flag) dones++;
        end
        chk("t5_no_done", 16'(dones), 16'd0);
        run_op("t5_c8x64", 8'hC8, 8'h64, 16'h4E20, 1'b0);

        // random sweep with operands scrambled after start
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("t6_rand", ra, rb, 16'(ra) * 16'(rb), 1'b1);
        end

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult8x8_seq_ctrl.md
Name: mult8x8_seq_ctrl

Overview:
Sequenced 8x8 unsigned multiplier built around one shared 4x4 partial-product multiplier and one 16-bit adder/accumulator. An internal FSM steps through the four nibble products, applies the correct shift to each, and accumulates them into a 16-bit result. The block sits in the mult8x8 lab datapath as the control-plus-accumulate core, and it handshakes with a host through start, busy and done_flag.

Parameters:
none (fixed 8-bit operands, 4-bit nibbles, 16-bit product)

Ports:
clk  input  1  rising-edge clock
reset_a  input  1  asynchronous, active-high reset
start  input  1  request a multiply; sampled only in IDLE
dataa  input  8  multiplicand; latched on accepted start
datab  input  8  multiplier; latched on accepted start
product8x8_out  output  16  final product; registered and held until the next completion
done_flag  output  1  one-cycle pulse; product8x8_out is valid in the same cycle
busy  output  1  high from the accepted start through the DONE state
state_out  output  3  current FSM state encoding, for debug/LEDs

Behaviour:
- Reset (async, reset_a=1):
  - state=IDLE.
  - a_r, b_r, acc, product8x8_out all 0.
  - done_flag=0, busy=0.
  - Reset releases synchronously on the next clk edge.
- State encodings for state_out: IDLE=0, LSB=1, MID1=2, MID2=3, MSB=4, DONE=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE:
  - On an edge with start=1: a_r<=dataa, b_r<=datab, acc<=0, go to LSB.
  - Otherwise stay in IDLE.
- Partial products use one 4x4 unsigned multiply of (sel_a nibble, sel_b nibble), giving an 8-bit result pp. The zero-extended shifted pp is added to acc through the 16-bit adder. Each state commits on its exiting edge:
  - LSB: a_r[3:0]*b_r[3:0], shift 0 -> MID1
  - MID1: a_r[7:4]*b_r[3:0], shift 4 -> MID2
  - MID2: a_r[3:0]*b_r[7:4], shift 4 -> MSB
  - MSB: a_r[7:4]*b_r[7:4], shift 8 -> DONE. On this edge product8x8_out is also loaded with the final sum (acc + pp<<8).
- DONE:
  - done_flag=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
  - start is ignored while in DONE.
- Latency: done_flag is high in the 5th cycle after the start-sampling edge (E0). Transitions: E1 LSB->MID1, E2->MID2, E3->MSB, E4->DONE, E5->IDLE.
  - Minimum start-to-start spacing is 6 cycles.
  - Throughput is one product per 6 cycles when start is held high.
- busy = (state != IDLE), decoded from registered state, so it has no glitch on start.
- Arithmetic:
  - Unsigned only.
  - Maximum result is 255*255 = 0xFE01, so no overflow. The adder's carry-out is discarded and is never set for legal inputs.
- Operand stability: dataa and datab may change freely after the start-sampling edge. Only a_r and b_r are used.
- start held high continuously: a new operation begins on the edge after DONE returns to IDLE, i.e. on E6 relative to the previous E0.
- Reset asserted mid-operation:
  - Immediate abort to reset values.
  - product8x8_out is cleared to 0.
  - No done_flag is produced.
- product8x8_out changes only on the MSB->DONE edge or on reset.

Test Plan:
1. Reset, then start with dataa=0x12, datab=0x34 -> done_flag pulses 1 cycle at E0+5 cycles; product8x8_out=0x03A8; busy high for 5 cycles.
2. dataa=0xFF, datab=0xFF -> product8x8_out=0xFE01. Then dataa=0x00, datab=0xA5 -> 0x0000. Then 0x80 x 0x02 -> 0x0100.
3. Pulse start with 0x0F x 0x10, then pulse start again with 0x33 x 0x33 in MID1 -> second start ignored; result 0x00F0; state returns to IDLE; no second done_flag.
4. Hold start=1 with 0x03 x 0x05 -> done_flag pulses every 6 cycles; product8x8_out=0x000F each time; busy low for exactly 1 cycle between operations.
5. Start 0xC8 x 0x64, assert reset_a asynchronously (mid-cycle) while in MID2 -> outputs 0 and state_out=0 immediately; no done_flag. After release, start 0xC8 x 0x64 -> 0x4E20.
6. Random sweep of 200 operand pairs, with operands changed the cycle after start -> every product8x8_out equals dataa*datab as latched; state_out follows 0,1,2,3,4,5,0.
